// File: rtl/clock_phaser_if.sv
// Request/status bundle between a machine-cycle controller and clock_phaser.
//
// Handshake: run, step_req and halt are plain level requests. The phaser
// samples them on every rising clk edge and has no ready signal; the
// controller sees a request accepted when running rises. A step_req that
// arrives while running=1 is dropped, not held.
interface clock_phaser_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step_req;
  logic             halt;
  logic             clk_core;
  logic             clk_d;
  logic             clk_e;
  logic             clk_s;
  logic             running;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_count;

  // Controller side: issues requests, observes phases and status.
  modport master (
    output run, step_req, halt,
    input  clk_core, clk_d, clk_e, clk_s, running, cycle_done, cycle_count
  );

  // Phaser side.
  modport slave (
    input  run, step_req, halt,
    output clk_core, clk_d, clk_e, clk_s, running, cycle_done, cycle_count
  );
endinterface

// File: rtl/clock_phaser.sv
// Four-quarter machine-cycle clock generator.
//
// A machine cycle is quarters q0..q3. Each quarter lasts DIV clk cycles,
// which a prescaler times. The FSM runs cycles back to back (RUN) or a single
// cycle (STEP). It decides whether to continue only at the boundary, which is
// the last clk of q3, so a cycle is never cut short by run or halt. Every
// output is a flop. Its next value is computed from the next FSM, quarter and
// prescaler values, so outputs line up with the state they describe and there
// is no input-to-output combinational path.
module clock_phaser #(
  parameter int DIV   = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  clock_phaser_if.slave     bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

  state_t      state, state_nxt;
  logic [1:0]  quarter, quarter_nxt;
  logic [7:0]  presc, presc_nxt;
  logic        at_boundary;

  logic        active_nxt;
  logic        core_nxt;
  logic        d_nxt;
  logic        done_nxt;

  logic             clk_core_q;
  logic             clk_d_q;
  logic             clk_e_q;
  logic             clk_s_q;
  logic             running_q;
  logic             cycle_done_q;
  logic [CNT_W-1:0] cycle_count_q;

  // Last clk of q3 while a cycle is in progress.
  assign at_boundary = (state != IDLE) && (quarter == 2'd3) &&
                       (presc == PRESC_LAST);

  // Next-state logic: start decision in IDLE, continue/stop decision only at
  // the boundary, otherwise advance the prescaler and quarter.
  always_comb begin
    state_nxt   = state;
    quarter_nxt = quarter;
    presc_nxt   = presc;
    case (state)
      IDLE: begin
        quarter_nxt = 2'd0;
        presc_nxt   = 8'd0;
        // halt vetoes both requests; run has priority over step_req.
        if (bus.run && !bus.halt) begin
          state_nxt = RUN;
        end else if (bus.step_req && !bus.halt) begin
          state_nxt = STEP;
        end
      end
      RUN, STEP: begin
        if (at_boundary) begin
          quarter_nxt = 2'd0;
          presc_nxt   = 8'd0;
          if ((state == RUN) && bus.run && !bus.halt) begin
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end else if (presc == PRESC_LAST) begin
          presc_nxt   = 8'd0;
          quarter_nxt = quarter + 2'd1;
        end else begin
          presc_nxt = presc + 8'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        quarter_nxt = 2'd0;
        presc_nxt   = 8'd0;
      end
    endcase
  end

  // Next output values, decoded from next quarter/prescaler.
  always_comb begin
    active_nxt = (state_nxt != IDLE);
    core_nxt   = active_nxt && !quarter_nxt[1];                 // q0, q1
    d_nxt      = active_nxt && (quarter_nxt[1] ^ quarter_nxt[0]); // q1, q2
    done_nxt   = active_nxt && (quarter_nxt == 2'd3) &&
                 (presc_nxt == PRESC_LAST);
  end

  // FSM, quarter and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      quarter <= 2'd0;
      presc   <= 8'd0;
    end else begin
      state   <= state_nxt;
      quarter <= quarter_nxt;
      presc   <= presc_nxt;
    end
  end

  // Registered phase and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_core_q   <= 1'b0;
      clk_d_q      <= 1'b0;
      clk_e_q      <= 1'b0;
      clk_s_q      <= 1'b0;
      running_q    <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      clk_core_q   <= core_nxt;
      clk_d_q      <= d_nxt;
      clk_e_q      <= core_nxt | d_nxt;
      clk_s_q      <= core_nxt & d_nxt;
      running_q    <= active_nxt;
      cycle_done_q <= done_nxt;
    end
  end

  // Completed-cycle counter. It steps on the edge that ends the boundary clk
  // and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_q <= '0;
    end else if (at_boundary) begin
      cycle_count_q <= cycle_count_q + 1'b1;
    end
  end

  assign bus.clk_core    = clk_core_q;
  assign bus.clk_d       = clk_d_q;
  assign bus.clk_e       = clk_e_q;
  assign bus.clk_s       = clk_s_q;
  assign bus.running     = running_q;
  assign bus.cycle_done  = cycle_done_q;
  assign bus.cycle_count = cycle_count_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_clock_phaser.sv
// Directed bench for clock_phaser. Inputs change and outputs are sampled on
// the falling clk edge. "clk n" is the clk period after rising edge n, and
// edge 0 samples the start request.
module tb_clock_phaser;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_phaser_if #(.CNT_W(16)) bus_a ();
  clock_phaser_if #(.CNT_W(4))  bus_b ();
  clock_phaser_if #(.CNT_W(16)) bus_c ();
  logic [1:0] state_a, state_b, state_c;

  clock_phaser #(.DIV(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a));
  clock_phaser #(.DIV(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b));
  clock_phaser #(.DIV(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c), .state_dbg(state_c));

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_vec(input string tag, input logic [31:0] obs,
                            input logic [31:0] e);
    exp_q.push_back(e);
    check(tag, obs, exp_q.pop_front());
  endtask

  // Reference phase table: {core, d, e, s, running, done} at position pos
  // (0-based clk within the cycle).
  function automatic logic [5:0] phase_vec(input int pos, input int div,
                                           input bit active);
    int   q;
    logic core, d;
    if (!active) return 6'b0;
    q    = pos / div;
    core = (q < 2);
    d    = (q == 1) || (q == 2);
    return {core, d, core | d, core & d, 1'b1, (pos == 4 * div - 1)};
  endfunction

  function automatic logic [31:0] pack(input logic [5:0] ph, input int cnt);
    return {8'h0, 16'(cnt), 2'b0, ph};
  endfunction

  function automatic logic [31:0] obs_a();
    return {8'h0, bus_a.cycle_count, 2'b0, bus_a.clk_core, bus_a.clk_d,
            bus_a.clk_e, bus_a.clk_s, bus_a.running, bus_a.cycle_done};
  endfunction

  function automatic logic [31:0] obs_b();
    return {8'h0, 12'h0, bus_b.cycle_count, 2'b0, bus_b.clk_core, bus_b.clk_d,
            bus_b.clk_e, bus_b.clk_s, bus_b.running, bus_b.cycle_done};
  endfunction

  function automatic logic [31:0] obs_c();
    return {8'h0, bus_c.cycle_count, 2'b0, bus_c.clk_core, bus_c.clk_d,
            bus_c.clk_e, bus_c.clk_s, bus_c.running, bus_c.cycle_done};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    bus_a.run = 0; bus_a.step_req = 0; bus_a.halt = 0;
    bus_b.run = 0; bus_b.step_req = 0; bus_b.halt = 0;
    bus_c.run = 0; bus_c.step_req = 0; bus_c.halt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    expect_vec("reset a", obs_a(), pack(6'b0, 0));
    expect_vec("reset b", obs_b(), pack(6'b0, 0));
    expect_vec("reset c", obs_c(), pack(6'b0, 0));
    check("reset state a", 32'(state_a), 32'd0);
    rst = 1'b0;

    // halt in IDLE blocks both run and step_req
    bus_a.run = 1; bus_a.halt = 1; bus_a.step_req = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      expect_vec($sformatf("halt blocks k=%0d", k), obs_a(), pack(6'b0, 0));
    end
    check("halt blocks state", 32'(state_a), 32'd0);
    bus_a.halt = 0; bus_a.step_req = 0;

    // free run; halt pulse mid-cycle ignored; halt held through a boundary stops
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      expect_vec($sformatf("run k=%0d", k), obs_a(),
                 (k <= 32) ? pack(phase_vec((k - 1) % 8, 2, 1), (k - 1) / 8)
                           : pack(6'b0, 4));
      if (k == 1) check("run state", 32'(state_a), 32'd1);
      bus_a.halt = (k == 19) || (k >= 27 && k <= 33);
      bus_a.run  = (k < 33);
    end

    // single step; a second step_req inside the cycle is dropped
    bus_a.step_req = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      expect_vec($sformatf("step k=%0d", k), obs_a(),
                 (k <= 8) ? pack(phase_vec(k - 1, 2, 1), 4) : pack(6'b0, 5));
      if (k == 1) check("step state", 32'(state_a), 32'd2);
      bus_a.step_req = (k == 3);
    end

    // asynchronous reset in clk 5 of a cycle
    bus_a.run = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      expect_vec($sformatf("pre-rst k=%0d", k), obs_a(),
                 pack(phase_vec(k - 1, 2, 1), 5));
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 expect_vec("rst async", obs_a(), pack(6'b0, 0));
    @(negedge clk);
    expect_vec("rst held", obs_a(), pack(6'b0, 0));
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      expect_vec($sformatf("post-rst k=%0d", k), obs_a(),
                 (k <= 8) ? pack(phase_vec(k - 1, 2, 1), 0) : pack(6'b0, 1));
      if (k == 1) bus_a.run = 0;
    end

    // CNT_W=4 wrap after 16 cycles
    pulses = 0;
    bus_b.run = 1;
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      if (bus_b.cycle_done) pulses++;
      if (k == 9)   expect_vec("wrap count k=9", obs_b(), pack(6'b0, 1) | 32'(phase_vec(0, 2, 1)));
      if (k == 120) expect_vec("wrap count k=120", obs_b(), pack(phase_vec(7, 2, 1), 14));
      if (k == 128) begin
        expect_vec("wrap count k=128", obs_b(), pack(phase_vec(7, 2, 1), 15));
        bus_b.run = 0;
      end
    end
    @(negedge clk);
    expect_vec("wrap to zero", obs_b(), pack(6'b0, 0));
    check("wrap done pulses", 32'(pulses), 32'd16);

    // DIV=1, run and step_req together: run wins, 4-clk cycles
    bus_c.run = 1; bus_c.step_req = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      expect_vec($sformatf("div1 k=%0d", k), obs_c(),
                 pack(phase_vec((k - 1) % 4, 1, 1), (k - 1) / 4));
      if (k == 1) begin
        check("div1 state", 32'(state_c), 32'd1);
        bus_c.step_req = 0;
      end
      if (k == 12) bus_c.run = 0;
    end
    @(negedge clk);
    expect_vec("div1 stop", obs_c(), pack(6'b0, 3));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_phaser.md
CLOCK_PHASER -- requirements
Module: clock_phaser

Interface
REQ-001 The block SHALL have parameter DIV, default 2, giving clk cycles per quarter-phase; legal range 1..255.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of cycle_count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: level request for free-running machine cycles.
REQ-006 The block SHALL have port step_req, input, 1 bit: request for exactly one machine cycle.
REQ-007 The block SHALL have port halt, input, 1 bit: level request to stop at the next machine-cycle boundary.
REQ-008 The block SHALL have port clk_core, output, 1 bit: the machine clock driven into the stepper.
REQ-009 The block SHALL have port clk_d, output, 1 bit: clk_core delayed by one quarter-phase.
REQ-010 The block SHALL have port clk_e, output, 1 bit: register-enable window, equal to clk_core OR clk_d.
REQ-011 The block SHALL have port clk_s, output, 1 bit: register-set pulse, equal to clk_core AND clk_d.
REQ-012 The block SHALL have port running, output, 1 bit: high while a machine cycle is in progress.
REQ-013 The block SHALL have port cycle_done, output, 1 bit: a one-clk pulse at the end of each machine cycle.
REQ-014 The block SHALL have port cycle_count, output, CNT_W bits: count of completed machine cycles.

Function
REQ-015 A machine cycle SHALL consist of quarters q0..q3, each lasting DIV clk cycles, timed by a prescaler counting 0..DIV-1.
REQ-016 The phase outputs SHALL follow this table:
  - clk_core = 1 in q0 and q1
  - clk_d = 1 in q1 and q2
  - clk_e = 1 in q0, q1 and q2
  - clk_s = 1 in q1 only
  - all phase outputs = 0 in IDLE
REQ-017 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-018 The FSM SHALL have states IDLE, RUN and STEP.
REQ-019 From IDLE, the FSM SHALL go to RUN when run=1 and halt=0, and to STEP when step_req=1, run=0 and halt=0.
REQ-020 If run=1 and step_req=1 together in IDLE, the FSM SHALL enter RUN (run wins).
REQ-021 halt=1 in IDLE SHALL block both run and step_req.
REQ-022 On entry to RUN or STEP, quarter and prescaler SHALL be 0, and clk_core, clk_e and running SHALL be 1 in the clk cycle after the sampling edge.
REQ-023 The boundary SHALL be the last clk of q3 (quarter=3, prescaler=DIV-1). In RUN at the boundary:
  - run=1 and halt=0: continue to q0
  - otherwise: go to IDLE
REQ-024 In STEP at the boundary, the FSM SHALL always go to IDLE.
REQ-025 run and halt SHALL be ignored between boundaries; a cycle is never truncated.
REQ-026 step_req SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-027 cycle_done SHALL be 1 during the boundary clk of every completed cycle, in both RUN and STEP.
REQ-028 cycle_count SHALL increment at the edge ending the boundary clk, wrapping from all-ones to 0.
REQ-029 running SHALL be 1 in RUN and STEP and 0 in IDLE; it falls in the clk after the final boundary.
REQ-030 With DIV=1, each quarter SHALL last exactly one clk, so a machine cycle is 4 clks.

Reset
REQ-031 While rst=1, the block SHALL immediately force:
  - FSM to IDLE
  - quarter and prescaler to 0
  - all phase outputs, running and cycle_done to 0
  - cycle_count to 0
REQ-032 rst SHALL take effect asynchronously mid-cycle, abandoning the cycle with no cycle_done and no count increment.
REQ-033 After rst is released, the first possible start SHALL be at the next rising edge of clk.

Verification
REQ-034 DIV=2, run held from edge 0. Required response:
  - clk_core=1 in clks 1-4; clk_d=1 in clks 3-6
  - clk_e=1 in clks 1-6; clk_s=1 in clks 3-4
  - cycle_done=1 in clk 8; cycle_count=1 after clk 8
  - pattern repeats from clk 9
REQ-035 DIV=2, one-clk step_req in IDLE -> exactly one 8-clk cycle, then running=0 at clk 9 and cycle_count=1; a second step_req during the cycle has no effect.
REQ-036 DIV=2, run running, halt=1 pulsed in clk 3 and low again by clk 8 -> current cycle completes, then the next cycle starts (halt not latched); halt held high through clk 8 -> IDLE after clk 8.
REQ-037 rst asserted in clk 5 of a cycle -> all outputs 0 in the same clk; cycle_count=0; no cycle_done.
REQ-038 CNT_W=4, 16 consecutive cycles from 0 -> cycle_count wraps to 0, with cycle_done pulses counted = 16.
REQ-039 DIV=1, run=1 and step_req=1 asserted simultaneously -> RUN is entered; 4-clk cycles continue while run=1.
